// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg : funct3 encodings, FSM states and op legality helper    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Misalignment or encoding errors only; the range check lives in the top.
  function automatic logic lsu_bad_op(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic bad;
    case (f3)
      c_f3_b:  bad = 1'b0;
      c_f3_h:  bad = lo[0];
      c_f3_w:  bad = |lo;
      c_f3_bu: bad = we;
      c_f3_hu: bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align : load lane extract/extend and store lane merge        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rword,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rword >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_load = i_rword;
    case (i_funct3)
      c_f3_b:  o_load = {{24{w_byte[7]}}, w_byte};
      c_f3_h:  o_load = {{16{w_half[15]}}, w_half};
      c_f3_bu: o_load = {24'd0, w_byte};
      c_f3_hu: o_load = {16'd0, w_half};
      default: o_load = i_rword;
    endcase
  end

  always_comb begin
    o_merged = i_rword;
    if (i_funct3[1:0] == 2'b00)
      o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
    else if (i_funct3[1:0] == 2'b01)
      o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_store_unit : RV32I byte/half/word load-store FSM with RMW   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] c_max_word = 32'(DMEM_BYTES - 4);

  lsu_state_e  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [15:0] r_wdata_lo;

  logic [31:0] w_word_addr;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready   = (r_state == IDLE);
  assign mem_addr    = {r_addr[31:2], 2'b00};
  assign w_word_addr = {req_addr[31:2], 2'b00};
  assign w_err       = lsu_bad_op(req_we, req_funct3, req_addr[1:0]) |
                       (w_word_addr > c_max_word);

  lsu_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_rword   (mem_rdata),
    .i_wdata   (r_wdata_lo),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata_lo <= 16'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_rw     <= 1'b0;
      mem_wdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      mem_rw     <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_we       <= req_we;
          r_funct3   <= req_funct3;
          r_addr     <= req_addr;
          r_wdata_lo <= req_wdata[15:0];
          if (w_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
            r_state    <= RESP;
          end else if (req_we && req_funct3 == c_f3_w) begin
            mem_wdata <= req_wdata;
            mem_rw    <= 1'b1;
            r_state   <= WR;
          end else begin
            // Loads and sub-word stores both need the current word first.
            r_state <= RD;
          end
        end
        RD: if (r_we) begin
          mem_wdata <= w_merged;
          mem_rw    <= 1'b1;
          r_state   <= WR;
        end else begin
          resp_rdata <= w_load;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          r_state    <= RESP;
        end
        WR: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          r_state    <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_load_store_unit : directed + random ops vs byte-level model   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int DMEM_BYTES = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic [7:0]  ref_b [DMEM_BYTES];
  logic        tb_wr_en = 1'b0;
  logic [5:0]  tb_wr_idx = 6'd0;
  logic [31:0] tb_wr_data = 32'd0;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.DMEM_BYTES(DMEM_BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_rw)        mem[mem_addr[7:2]] <= mem_wdata;
    else if (tb_wr_en) mem[tb_wr_idx]     <= tb_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    return {ref_b[wa+3], ref_b[wa+2], ref_b[wa+1], ref_b[wa]};
  endfunction

  function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    if (we && f3[2]) return 1'b1;
    size = 1 << f3[1:0];
    if ((a % size) != 0) return 1'b1;
    if ((a & 32'hFFFF_FFFC) > 32'(DMEM_BYTES - 4)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_wr_en = 1'b1;
    tb_wr_idx = a[7:2];
    tb_wr_data = d;
    for (int i = 0; i < 4; i++) ref_b[(a & 32'hFC) + i] = d[8*i +: 8];
    @(negedge clk);
    tb_wr_en = 1'b0;
  endtask

  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit noisy, output logic [31:0] obs);
    bit          e_err;
    int          e_lat, e_writes, size, lat, writes;
    logic [31:0] e_rdata, e_wword, w_word, w_addr, mask;
    bit          got;
    e_err = ref_err(we, f3, a);
    size = 1 << f3[1:0];
    e_rdata = 32'd0; e_wword = 32'd0; e_writes = 0;
    if (e_err) e_lat = 1;
    else if (!we) begin
      e_lat = 2;
      for (int i = 0; i < size; i++) e_rdata[8*i +: 8] = ref_b[a + i];
      if (!f3[2] && size < 4) begin
        mask = (32'd1 << (8*size)) - 1;
        if (e_rdata[8*size-1]) e_rdata = e_rdata | ~mask;
      end
    end else begin
      e_lat = (size == 4) ? 2 : 3;
      e_writes = 1;
      for (int i = 0; i < size; i++) ref_b[a + i] = wd[8*i +: 8];
      e_wword = ref_word(a);
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    got = 0; lat = 0; writes = 0; w_word = 32'd0; w_addr = 32'd0;
    for (int n = 1; n <= 6; n++) begin
      if (mem_rw) begin writes++; w_word = mem_wdata; w_addr = mem_addr; end
      if (resp_valid) begin got = 1; lat = n; break; end
      if (noisy) begin
        req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom_range(0, 2));
        req_addr = 32'($urandom_range(0, 63)) & 32'hFC; req_wdata = $urandom;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    obs = resp_rdata;
    chk("resp_seen", {31'd0, got}, 32'd1);
    chk("latency", lat, e_lat);
    chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
    chk("resp_rdata", resp_rdata, e_rdata);
    chk("write_count", writes, e_writes);
    if (e_writes != 0) begin
      chk("mem_wdata", w_word, e_wword);
      chk("mem_addr", w_addr, a & 32'hFFFF_FFFC);
    end
    @(negedge clk);
    chk("resp_valid_low", {31'd0, resp_valid}, 32'd0);
    chk("rdata_hold", resp_rdata, e_rdata);
  endtask

  initial begin
    logic [31:0] obs;
    int          pulses;
    for (int i = 0; i < 64; i++) poke(32'(i * 4), $urandom);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    poke(32'h10, 32'h80FF7F01);
    do_op(0, 3'b000, 32'h13, 32'd0, 0, obs); chk("lb_0x13", obs, 32'hFFFFFF80);
    do_op(0, 3'b101, 32'h12, 32'd0, 0, obs); chk("lhu_0x12", obs, 32'h000080FF);
    do_op(0, 3'b001, 32'h12, 32'd0, 0, obs); chk("lh_0x12", obs, 32'hFFFF80FF);
    do_op(0, 3'b100, 32'h11, 32'd0, 0, obs); chk("lbu_0x11", obs, 32'h0000007F);

    poke(32'h20, 32'h11223344);
    do_op(1, 3'b000, 32'h21, 32'h000000AB, 0, obs);
    do_op(0, 3'b010, 32'h20, 32'd0, 0, obs); chk("lw_after_sb", obs, 32'h1122AB44);
    do_op(1, 3'b001, 32'h22, 32'h0000CAFE, 0, obs);
    do_op(0, 3'b010, 32'h20, 32'd0, 0, obs); chk("lw_after_sh", obs, 32'hCAFEAB44);

    do_op(1, 3'b010, 32'h22, 32'hDEADBEEF, 0, obs);
    do_op(0, 3'b010, 32'h20, 32'd0, 0, obs); chk("mem_unchanged", obs, 32'hCAFEAB44);
    do_op(0, 3'b010, 32'hFC, 32'd0, 0, obs);
    do_op(0, 3'b010, 32'h100, 32'd0, 0, obs);
    do_op(1, 3'b100, 32'h40, 32'h12345678, 0, obs);
    do_op(0, 3'b011, 32'h40, 32'd0, 0, obs);

    // Reset lands in the RD cycle of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h30; req_wdata = 32'h5555;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    pulses = 0;
    @(negedge clk);
    pulses += int'(mem_rw) + int'(resp_valid);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      pulses += int'(mem_rw) + int'(resp_valid);
      @(negedge clk);
    end
    chk("midrst_no_pulse", pulses, 0);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DMEM_BYTES + 3));
      do_op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, 1'($urandom), obs);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(32'(i * 4)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DMEM_BYTES, default 256, giving the data-memory size in bytes; an access whose aligned word exceeds it is an error.
REQ-002 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is rst_n, synchronous, active-low; clock clk.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the core presents a memory op.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the unit accepts the op this cycle.
REQ-006 The block SHALL have port req_we, input, 1, where 1 is a store and 0 is a load.
REQ-007 The block SHALL have port req_funct3, input, 3, carrying RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-010 The block SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata, output, 32, the extended load result.
REQ-012 The block SHALL have port resp_err, output, 1, flagging a misaligned, illegal, or out-of-range op; it is valid with resp_valid.
REQ-013 The block SHALL have port mem_addr, output, 32, the word-aligned address to the data memory.
REQ-014 The block SHALL have port mem_wdata, output, 32, the full word to write.
REQ-015 The block SHALL have port mem_rw, output, 1, where 0 is read and 1 is write; the memory writes on clk rise while 1.
REQ-016 The block SHALL have port mem_rdata, input, 32, the combinational read word, little-endian.

Function
REQ-017 The FSM SHALL have states IDLE, RD, WR and RESP; req_ready is 1 only in IDLE.
REQ-018 An op SHALL be accepted when req_valid and req_ready are both 1; req_we, req_funct3, req_addr and req_wdata are registered at acceptance.
REQ-019 mem_addr SHALL equal {addr_q[31:2],2'b00}, and the block SHALL never present a non-word-aligned address.
REQ-020 Error check at acceptance: H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 of 011/110/111, store funct3 of 100/101, or aligned word > DMEM_BYTES-4 SHALL go IDLE->RESP with resp_err=1, with no write and resp_rdata=0.
REQ-021 A load SHALL follow IDLE->RD->RESP, capturing mem_rdata in RD, so resp_valid rises 2 cycles after acceptance.
REQ-022 A load's lane SHALL be selected by addr[1:0] (byte) or addr[1] (half); B/H sign-extend and BU/HU zero-extend to 32 bits.
REQ-023 A SW SHALL follow IDLE->WR->RESP with mem_wdata=wdata_q.
REQ-024 SB/SH SHALL use read-modify-write, IDLE->RD->WR->RESP: the RD word is captured, wdata_q[7:0] or wdata_q[15:0] is merged into the addressed lane, and the other bytes are preserved.
REQ-025 mem_rw SHALL be 1 only in WR, for exactly one cycle per store, and 0 in every other state.
REQ-026 resp_valid SHALL be 1 only in RESP for one cycle, after which the FSM returns to IDLE; there is no response backpressure.
REQ-027 resp_rdata SHALL be 0 for stores and hold its last value while resp_valid=0.
REQ-028 req_valid asserted outside IDLE SHALL be ignored and not queued.

Reset
REQ-029 While rst_n=0 at a clk edge, the state SHALL go to IDLE and all registers clear: resp_valid=0, resp_err=0, resp_rdata=0, mem_rw=0, mem_wdata=0, mem_addr=0.
REQ-030 Reset mid-op (RD or WR) SHALL abort the op with no write after reset and no resp_valid.
REQ-031 req_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 constants and the state enum {IDLE,RD,WR,RESP}.
REQ-033 One combinational sub-module, lsu_align, SHALL perform lane extract/extend and lane merge; the FSM and registers stay in load_store_unit.

Verification
REQ-034 Test: mem word 0x80FF7F01 at addr 0x10, LB at 0x13 -> resp_rdata 0xFFFFFF80, with resp_valid at acceptance+2.
REQ-035 Test: same word, LHU at 0x12 -> resp_rdata 0x000080FF; LH at 0x12 -> 0xFFFF80FF.
REQ-036 Test: mem 0x11223344 at 0x20, SB 0xAB at 0x21 -> one mem_rw pulse with mem_wdata 0x1122AB44; a following LW at 0x20 returns 0x1122AB44.
REQ-037 Test: SW 0xDEADBEEF at 0x22 -> resp_err=1 at acceptance+1, mem_rw never 1, memory unchanged.
REQ-038 Test: SH accepted, then rst_n=0 in the RD cycle -> no mem_rw pulse, no resp_valid, and req_ready=1 after release.
REQ-039 Test: LW at 0xFC with DMEM_BYTES=256 -> passes; LW at 0x100 -> resp_err=1.
